// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state and machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data requesters, one grant per access.
// Optional ARB_STARVE_EN bounds how long an instruction request can be starved by data.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t state, next_state;
  logic   dreq;

`ifdef ARB_STARVE_EN
  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt, starve_cnt_next;
  logic          starve_hit;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
`ifdef ARB_STARVE_EN
      starve_cnt <= '0;
`endif
    end else begin
      state <= next_state;
`ifdef ARB_STARVE_EN
      starve_cnt <= starve_cnt_next;
`endif
    end
  end

  always_comb begin
    dreq       = dREN | dWEN;
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = iREN;
    dwait      = dREN | dWEN;
    iload      = ramload;
    dload      = ramload;
`ifdef ARB_STARVE_EN
    starve_hit      = iREN && (starve_cnt == STARVE_LIM);
    starve_cnt_next = starve_cnt;
`endif

    case (state)
      IDLE: begin
`ifdef ARB_STARVE_EN
        if (starve_hit)  next_state = ISERV;
        else if (dreq)   next_state = DSERV;
        else if (iREN)   next_state = ISERV;
`else
        if (dreq)        next_state = DSERV;
        else if (iREN)   next_state = ISERV;
`endif
      end
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = 1'b1;
        // A dropped request aborts without signalling completion, even on ACCESS.
        if (!dreq) next_state = IDLE;
        else if (ramstate == ACCESS) begin
          dwait      = 1'b0;
          next_state = IDLE;
        end else if (ramstate == ERROR) next_state = IDLE;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = 1'b1;
        if (!iREN) next_state = IDLE;
        else if (ramstate == ACCESS) begin
          iwait      = 1'b0;
          next_state = IDLE;
        end else if (ramstate == ERROR) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

`ifdef ARB_STARVE_EN
    if (!iREN) starve_cnt_next = '0;
    else if (state == IDLE && next_state == ISERV) starve_cnt_next = '0;
    else if (state == IDLE && next_state == DSERV && starve_cnt != STARVE_LIM)
      starve_cnt_next = starve_cnt + 1'b1;
`endif
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle expected outputs queued with each stimulus row.
// Expectations for the starvation scenario follow ARB_STARVE_EN.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST = 1'b0;
  logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  ramstate_t ramstate = FREE;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic ren, wen;
    logic [31:0] addr, store;
    logic iw, dw;
    logic [31:0] il, dl;
  } obs_t;

  typedef struct packed {
    logic iren, dren, dwen;
    logic [31:0] ia, da, ds, rl;
    ramstate_t rs;
  } stim_t;

  obs_t sb[$];
  int   total = 0;
  int   passed = 0;

  function automatic stim_t S(input logic ir, dr, dw, input logic [31:0] ia, da, ds, rl,
                              input ramstate_t rs);
    return '{iren: ir, dren: dr, dwen: dw, ia: ia, da: da, ds: ds, rl: rl, rs: rs};
  endfunction

  function automatic obs_t E(input logic ren, wen, input logic [31:0] addr, store,
                             input logic iw, dw, input logic [31:0] ld);
    return '{ren: ren, wen: wen, addr: addr, store: store, iw: iw, dw: dw, il: ld, dl: ld};
  endfunction

  function automatic obs_t snap();
    return '{ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore,
             iw: iwait, dw: dwait, il: iload, dl: dload};
  endfunction

  task automatic apply(input stim_t s);
    iREN = s.iren; dREN = s.dren; dWEN = s.dwen;
    iaddr = s.ia; daddr = s.da; dstore = s.ds; ramload = s.rl; ramstate = s.rs;
  endtask

  task automatic test_reset();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    nRST = 1'b0;
    st.push_back(S(1, 1, 0, 'h10, 'h20, 'h30, 'h1234, ACCESS)); ex.push_back(E(0, 0, 0, 0, 1, 1, 'h1234));
    st.push_back(S(0, 0, 1, 'h10, 'h20, 'h30, 'h00A5, BUSY));   ex.push_back(E(0, 0, 0, 0, 0, 1, 'h00A5));
    st.push_back(S(0, 0, 0, 'h10, 'h20, 'h30, 'h0000, FREE));   ex.push_back(E(0, 0, 0, 0, 0, 0, 'h0000));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL reset[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
    nRST = 1'b1;
  endtask

  task automatic test_data_read();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(0, 1, 0, 0, 'h100, 0, 0, FREE));           ex.push_back(E(0, 0, 0, 0, 0, 1, 0));
    st.push_back(S(0, 1, 0, 0, 'h100, 0, 0, BUSY));           ex.push_back(E(1, 0, 'h100, 0, 0, 1, 0));
    st.push_back(S(0, 1, 0, 0, 'h100, 0, 0, BUSY));           ex.push_back(E(1, 0, 'h100, 0, 0, 1, 0));
    st.push_back(S(0, 1, 0, 0, 'h100, 0, 'hDEADBEEF, ACCESS)); ex.push_back(E(1, 0, 'h100, 0, 0, 0, 'hDEADBEEF));
    st.push_back(S(0, 0, 0, 0, 'h100, 0, 'h11, FREE));        ex.push_back(E(0, 0, 0, 0, 0, 0, 'h11));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL data_read[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 1, 1, 'h80, 'h40, 5, 0, FREE));      ex.push_back(E(0, 0, 0, 0, 1, 1, 0));
    st.push_back(S(1, 1, 1, 'h80, 'h40, 5, 0, BUSY));      ex.push_back(E(0, 1, 'h40, 5, 1, 1, 0));
    st.push_back(S(1, 1, 1, 'h80, 'h40, 5, 'h22, ACCESS)); ex.push_back(E(0, 1, 'h40, 5, 1, 0, 'h22));
    st.push_back(S(1, 0, 0, 'h80, 'h40, 5, 0, FREE));      ex.push_back(E(0, 0, 0, 0, 1, 0, 0));
    st.push_back(S(1, 0, 0, 'h80, 'h40, 5, 0, BUSY));      ex.push_back(E(1, 0, 'h80, 0, 1, 0, 0));
    st.push_back(S(1, 0, 0, 'h80, 'h40, 5, 'h77, ACCESS)); ex.push_back(E(1, 0, 'h80, 0, 0, 0, 'h77));
    st.push_back(S(0, 0, 0, 'h80, 'h40, 5, 0, FREE));      ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL priority[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_flush();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 0, 0, 'h200, 0, 0, 0, FREE)); ex.push_back(E(0, 0, 0, 0, 1, 0, 0));
    st.push_back(S(1, 0, 0, 'h200, 0, 0, 0, BUSY)); ex.push_back(E(1, 0, 'h200, 0, 1, 0, 0));
    st.push_back(S(0, 0, 0, 'h200, 0, 0, 0, BUSY)); ex.push_back(E(0, 0, 'h200, 0, 1, 0, 0));
    st.push_back(S(0, 0, 0, 'h200, 0, 0, 0, FREE)); ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL flush[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_error();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(0, 1, 0, 0, 'h300, 0, 0, FREE));       ex.push_back(E(0, 0, 0, 0, 0, 1, 0));
    st.push_back(S(0, 1, 0, 0, 'h300, 0, 0, ERROR));      ex.push_back(E(1, 0, 'h300, 0, 0, 1, 0));
    st.push_back(S(0, 1, 0, 0, 'h300, 0, 0, FREE));       ex.push_back(E(0, 0, 0, 0, 0, 1, 0));
    st.push_back(S(0, 1, 0, 0, 'h300, 0, 'hCAFE, ACCESS)); ex.push_back(E(1, 0, 'h300, 0, 0, 0, 'hCAFE));
    st.push_back(S(0, 0, 0, 0, 'h300, 0, 0, FREE));       ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL error[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_starve();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    bit starve_on;
`ifdef ARB_STARVE_EN
    starve_on = 1'b1;
`else
    starve_on = 1'b0;
`endif
    // Every access completes at once, so even cycles are arbitration bubbles.
    for (int k = 0; k < 20; k++) begin
      st.push_back(S(1, 1, 0, 'h600, 'h500, 0, 'h5A, ACCESS));
      if (k % 2 == 0)                          ex.push_back(E(0, 0, 0, 0, 1, 1, 'h5A));
      else if (starve_on && (k == 9 || k == 19)) ex.push_back(E(1, 0, 'h600, 0, 0, 1, 'h5A));
      else                                     ex.push_back(E(1, 0, 'h500, 0, 1, 0, 'h5A));
    end
    st.push_back(S(0, 0, 0, 'h600, 'h500, 0, 'h5A, FREE)); ex.push_back(E(0, 0, 0, 0, 0, 0, 'h5A));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL starve[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$]; obs_t ex[$]; obs_t got, want;
    st.push_back(S(1, 0, 1, 'h800, 'h700, 9, 0, FREE)); ex.push_back(E(0, 0, 0, 0, 1, 1, 0));
    st.push_back(S(1, 0, 1, 'h800, 'h700, 9, 0, BUSY)); ex.push_back(E(0, 1, 'h700, 9, 1, 1, 0));
    st.push_back(S(1, 0, 1, 'h800, 'h700, 9, 0, BUSY)); ex.push_back(E(0, 1, 'h700, 9, 1, 1, 0));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL reset_mid[%0d] got=%h want=%h", k, got, want);
      else passed++;
      if (k < st.size() - 1) begin
        @(posedge CLK); #1;
      end
    end
    #1 nRST = 1'b0;
    sb.push_back(E(0, 0, 0, 0, 1, 1, 0));
    #1;
    got = snap(); want = sb.pop_front(); total++;
    if (got !== want) $display("FAIL reset_mid_async got=%h want=%h", got, want);
    else passed++;
`ifdef ARB_STARVE_EN
    total++;
    if (dut.starve_cnt !== '0) $display("FAIL reset_mid_cnt got=%0d want=0", dut.starve_cnt);
    else passed++;
`endif
    @(posedge CLK); #1;
    nRST = 1'b1;
    st.delete(); ex.delete();
    st.push_back(S(1, 0, 1, 'h800, 'h700, 9, 0, FREE));   ex.push_back(E(0, 0, 0, 0, 1, 1, 0));
    st.push_back(S(1, 0, 1, 'h800, 'h700, 9, 0, ACCESS)); ex.push_back(E(0, 1, 'h700, 9, 1, 0, 0));
    st.push_back(S(0, 0, 0, 'h800, 'h700, 9, 0, FREE));   ex.push_back(E(0, 0, 0, 0, 0, 0, 0));
    foreach (st[k]) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge CLK);
      got = snap(); want = sb.pop_front(); total++;
      if (got !== want) $display("FAIL after_reset[%0d] got=%h want=%h", k, got, want);
      else passed++;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_data_read();
    test_priority();
    test_flush();
    test_error();
    test_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
